// File: rtl/red_pitaya_exp_pkg.sv
// ---------------------------------------------------------------------------
// red_pitaya_exp_pkg
// Shared definitions for the expansion-connector debouncer:
//   - debounce counter width and DEB_LEN reset value
//   - sys-bus register offsets and a decoder to a register-select enum
// ---------------------------------------------------------------------------
package red_pitaya_exp_pkg;

    localparam int              CNT_W       = 16;
    localparam logic [CNT_W-1:0] DEB_LEN_RST = 16'd1000;

    localparam logic [31:0] ADDR_DEB_LEN = 32'h0000_0000;
    localparam logic [31:0] ADDR_RISE_EN = 32'h0000_0004;
    localparam logic [31:0] ADDR_FALL_EN = 32'h0000_0008;
    localparam logic [31:0] ADDR_STATUS  = 32'h0000_000C;
    localparam logic [31:0] ADDR_STABLE  = 32'h0000_0010;
    localparam logic [31:0] ADDR_SYNC    = 32'h0000_0014;

    typedef enum logic [2:0] {
        REG_DEB_LEN,
        REG_RISE_EN,
        REG_FALL_EN,
        REG_STATUS,
        REG_STABLE,
        REG_SYNC,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        reg_sel_e sel;
        case (addr)
            ADDR_DEB_LEN: sel = REG_DEB_LEN;
            ADDR_RISE_EN: sel = REG_RISE_EN;
            ADDR_FALL_EN: sel = REG_FALL_EN;
            ADDR_STATUS:  sel = REG_STATUS;
            ADDR_STABLE:  sel = REG_STABLE;
            ADDR_SYNC:    sel = REG_SYNC;
            default:      sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/red_pitaya_deb_bit.sv
// ---------------------------------------------------------------------------
// red_pitaya_deb_bit
// One connector pin: 2-flop synchronizer, tick-based debounce counter and
// the debounced (stable) level.
// Ports:
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   tick_i         one-cycle debounce tick from the shared prescaler
//   deb_len_i      ticks a new level must persist (0 = bypass)
//   raw_i          asynchronous pin
//   sync_o         synchronized pin level
//   stable_o       debounced level
// ---------------------------------------------------------------------------
module red_pitaya_deb_bit
    import red_pitaya_exp_pkg::*;
(
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] deb_len_i,
    input  logic             raw_i,
    output logic             sync_o,
    output logic             stable_o
);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_inc;

    always_comb begin
        // One extra bit so a counter left above a freshly lowered DEB_LEN
        // still compares correctly and never wraps.
        cnt_inc  = {1'b0, cnt_q} + 17'd1;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (deb_len_i == '0) begin
            stable_d = sync_q;
            cnt_d    = '0;
        end else if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_inc >= {1'b0, deb_len_i}) begin
                stable_d = sync_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_inc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= raw_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sync_o   = sync_q;
    assign stable_o = stable_q;

endmodule

// File: rtl/red_pitaya_exp_debounce.sv
// ---------------------------------------------------------------------------
// red_pitaya_exp_debounce
// Debounces the 2*DWE expansion-connector pins (P and N) and exposes them
// through a sys-bus register block. Optional edge capture with sticky W1C
// status and a level interrupt is built only when EXP_DEB_IRQ_EN is defined;
// otherwise RISE_EN/FALL_EN/STATUS read 0 and irq_o is 0.
// Ports:
//   clk_i, rstn_i                 clock, asynchronous active-low reset
//   exp_p_raw_i, exp_n_raw_i      raw pins
//   exp_p_dat_o, exp_n_dat_o      debounced levels
//   irq_o                         OR of status bits, registered
//   sys_*                         sys-bus slave (ack one cycle after wen/ren)
// Bit packing in registers: [DWE-1:0] = P, [2*DWE-1:DWE] = N.
// ---------------------------------------------------------------------------
module red_pitaya_exp_debounce
    import red_pitaya_exp_pkg::*;
#(
    parameter int DWE   = 8,
    parameter int PRESC = 125
)(
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic [DWE-1:0] exp_p_raw_i,
    input  logic [DWE-1:0] exp_n_raw_i,
    output logic [DWE-1:0] exp_p_dat_o,
    output logic [DWE-1:0] exp_n_dat_o,
    output logic           irq_o,
    input  logic [31:0]    sys_addr,
    input  logic [31:0]    sys_wdata,
    input  logic [3:0]     sys_sel,
    input  logic           sys_wen,
    input  logic           sys_ren,
    output logic [31:0]    sys_rdata,
    output logic           sys_err,
    output logic           sys_ack
);

    localparam int              NB        = 2 * DWE;
    localparam int              PW        = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESC - 1);

    logic [NB-1:0]    raw_all, sync_all, stable_all;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;
    logic [CNT_W-1:0] deb_len_q, deb_len_d;
    logic             ack_q;
    logic [31:0]      rdata_q, rdata_d;
    reg_sel_e         sel;
    logic [NB-1:0]    rise_en_rd, fall_en_rd, status_rd;
    logic             irq_rd;
    logic             unused_bus;

    assign raw_all = {exp_n_raw_i, exp_p_raw_i};
    assign sel     = decode_addr(sys_addr);

    // Free-running prescaler; tick is high on the PRESC-1 -> 0 wrap cycle.
    assign tick    = (presc_q == PRESC_MAX);
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    for (genvar g = 0; g < NB; g++) begin : g_bit
        red_pitaya_deb_bit u_bit (
            .clk_i     (clk_i),
            .rstn_i    (rstn_i),
            .tick_i    (tick),
            .deb_len_i (deb_len_q),
            .raw_i     (raw_all[g]),
            .sync_o    (sync_all[g]),
            .stable_o  (stable_all[g])
        );
    end

`ifdef EXP_DEB_IRQ_EN
    logic [NB-1:0] rise_en_q, fall_en_q, status_q, status_d, stable_prev_q;
    logic [NB-1:0] edge_set, status_clr;
    logic          irq_q;

    always_comb begin
        edge_set   = (stable_all & ~stable_prev_q & rise_en_q)
                   | (~stable_all & stable_prev_q & fall_en_q);
        status_clr = (sys_wen && sel == REG_STATUS) ? sys_wdata[NB-1:0] : '0;
        // Set after clear: a new edge in the clearing cycle is not lost.
        status_d   = (status_q & ~status_clr) | edge_set;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rise_en_q     <= '0;
            fall_en_q     <= '0;
            status_q      <= '0;
            stable_prev_q <= '0;
            irq_q         <= 1'b0;
        end else begin
            if (sys_wen && sel == REG_RISE_EN) rise_en_q <= sys_wdata[NB-1:0];
            if (sys_wen && sel == REG_FALL_EN) fall_en_q <= sys_wdata[NB-1:0];
            status_q      <= status_d;
            stable_prev_q <= stable_all;
            irq_q         <= |status_q;
        end
    end

    assign rise_en_rd = rise_en_q;
    assign fall_en_rd = fall_en_q;
    assign status_rd  = status_q;
    assign irq_rd     = irq_q;
`else
    assign rise_en_rd = '0;
    assign fall_en_rd = '0;
    assign status_rd  = '0;
    assign irq_rd     = 1'b0;
`endif

    always_comb begin
        deb_len_d = deb_len_q;
        if (sys_wen && sel == REG_DEB_LEN) deb_len_d = sys_wdata[CNT_W-1:0];

        rdata_d = '0;
        case (sel)
            REG_DEB_LEN: rdata_d[CNT_W-1:0] = deb_len_q;
            REG_RISE_EN: rdata_d[NB-1:0]    = rise_en_rd;
            REG_FALL_EN: rdata_d[NB-1:0]    = fall_en_rd;
            REG_STATUS:  rdata_d[NB-1:0]    = status_rd;
            REG_STABLE:  rdata_d[NB-1:0]    = stable_all;
            REG_SYNC:    rdata_d[NB-1:0]    = sync_all;
            default:     rdata_d            = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            presc_q   <= '0;
            deb_len_q <= DEB_LEN_RST;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            presc_q   <= presc_d;
            deb_len_q <= deb_len_d;
            ack_q     <= sys_wen | sys_ren;
            if (sys_ren) rdata_q <= rdata_d;
        end
    end

    // Byte selects and upper write-data bits have no meaning here.
    assign unused_bus = ^{sys_sel, sys_wdata[31:CNT_W]};

    assign exp_p_dat_o = stable_all[DWE-1:0];
    assign exp_n_dat_o = stable_all[NB-1:DWE];
    assign irq_o       = irq_rd;
    assign sys_rdata   = rdata_q;
    assign sys_ack     = ack_q;
    assign sys_err     = 1'b0;

endmodule

// File: tb/tb_red_pitaya_exp_debounce.sv
module tb_red_pitaya_exp_debounce;

    localparam int DWE   = 8;
    localparam int PRESC = 125;
    localparam int NB    = 2 * DWE;
`ifdef EXP_DEB_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rstn;
    logic [DWE-1:0] raw_p, raw_n, dat_p, dat_n;
    logic           irq;
    logic [31:0]    sys_addr, sys_wdata, sys_rdata;
    logic [3:0]     sys_sel;
    logic           sys_wen, sys_ren, sys_err, sys_ack;

    red_pitaya_exp_debounce #(.DWE(DWE), .PRESC(PRESC)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .exp_p_raw_i (raw_p),
        .exp_n_raw_i (raw_n),
        .exp_p_dat_o (dat_p),
        .exp_n_dat_o (dat_n),
        .irq_o       (irq),
        .sys_addr    (sys_addr),
        .sys_wdata   (sys_wdata),
        .sys_sel     (sys_sel),
        .sys_wen     (sys_wen),
        .sys_ren     (sys_ren),
        .sys_rdata   (sys_rdata),
        .sys_err     (sys_err),
        .sys_ack     (sys_ack)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int step_n = 0;

    // Reference model: pin history, debounced level, ticks spent disagreeing.
    logic [NB-1:0] m_hist1, m_hist2, m_stable;
    int            m_ticks [NB];
    int            m_cyc;
    int            m_len;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] e;
        string       nm;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_hist1  = '0;
        m_hist2  = '0;
        m_stable = '0;
        m_cyc    = 0;
        m_len    = 1000;
        for (int b = 0; b < NB; b++) m_ticks[b] = 0;
    endtask

    // A pin's debounced level adopts its synchronized level once that level
    // has disagreed for m_len consecutive ticks (immediately when m_len==0).
    task automatic model_edge();
        bit is_tick;
        is_tick = ((m_cyc % PRESC) == PRESC - 1);
        for (int b = 0; b < NB; b++) begin
            if (m_len == 0) begin
                m_stable[b] = m_hist2[b];
                m_ticks[b]  = 0;
            end else if (m_hist2[b] == m_stable[b]) begin
                m_ticks[b] = 0;
            end else if (is_tick) begin
                m_ticks[b] = m_ticks[b] + 1;
                if (m_ticks[b] >= m_len) begin
                    m_stable[b] = m_hist2[b];
                    m_ticks[b]  = 0;
                end
            end
        end
        m_hist2 = m_hist1;
        m_hist1 = {raw_n, raw_p};
        if (sys_wen && sys_addr == 32'h0) m_len = int'(sys_wdata[15:0]);
        m_cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rstn) model_reset();
        else       model_edge();
        @(negedge clk);
        step_n++;
        if (rstn && (step_n % 4 == 0))
            chk("dat_vs_model", {16'h0, dat_n, dat_p}, {16'h0, m_stable});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd);
        sys_addr  = a;
        sys_wdata = d;
        sys_wen   = wr;
        sys_ren   = !wr;
        step();
        sys_wen = 1'b0;
        sys_ren = 1'b0;
        chk("ack_1cyc", {31'h0, sys_ack}, 32'h1);
        chk("err_zero", {31'h0, sys_err}, 32'h0);
        rd = sys_rdata;
        step();
        chk("ack_single", {31'h0, sys_ack}, 32'h0);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        logic [31:0] rd;
        bus(1'b0, a, 32'h0, rd);
        chk(nm, rd, e);
    endtask

    task automatic add_vec(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] e, input string nm);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.e = e; v.nm = nm;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] rd;
        logic        old;
        int          cnt;
        bit          found;
        logic [NB-1:0] mask;

        rstn = 1'b0;
        raw_p = '0; raw_n = '0;
        sys_addr = '0; sys_wdata = '0; sys_sel = 4'hF; sys_wen = 1'b0; sys_ren = 1'b0;
        model_reset();
        steps(3);
        chk("rst_dat",   {16'h0, dat_n, dat_p}, 32'h0);
        chk("rst_irq",   {31'h0, irq}, 32'h0);
        chk("rst_ack",   {31'h0, sys_ack}, 32'h0);
        chk("rst_rdata", sys_rdata, 32'h0);
        rstn = 1'b1;
        step();

        // Register map vectors
        add_vec(0, 32'h00, 32'h0,    32'd1000,                        "deblen_reset");
        add_vec(1, 32'h00, 32'd5,    32'h0,                           "deblen_wr");
        add_vec(0, 32'h00, 32'h0,    32'd5,                           "deblen_rd");
        add_vec(1, 32'h04, 32'hA5A5, 32'h0,                           "rise_wr");
        add_vec(0, 32'h04, 32'h0,    IRQ_ON ? 32'hA5A5 : 32'h0,       "rise_rd");
        add_vec(1, 32'h08, 32'h5A5A, 32'h0,                           "fall_wr");
        add_vec(0, 32'h08, 32'h0,    IRQ_ON ? 32'h5A5A : 32'h0,       "fall_rd");
        add_vec(0, 32'h0C, 32'h0,    32'h0,                           "status_idle");
        add_vec(0, 32'h20, 32'h0,    32'h0,                           "unmapped_rd");
        add_vec(1, 32'h10, 32'h1234, 32'h0,                           "stable_ro_wr");
        add_vec(0, 32'h10, 32'h0,    32'h0,                           "stable_ro_rd");
        add_vec(1, 32'h14, 32'h00FF, 32'h0,                           "sync_ro_wr");
        add_vec(0, 32'h14, 32'h0,    32'h0,                           "sync_ro_rd");
        add_vec(1, 32'h04, 32'h0,    32'h0,                           "rise_clr");
        add_vec(1, 32'h08, 32'h0,    32'h0,                           "fall_clr");
        for (int i = 0; i < tbl.size(); i++) begin
            bus(tbl[i].wr, tbl[i].a, tbl[i].d, rd);
            if (!tbl[i].wr) chk(tbl[i].nm, rd, tbl[i].e);
        end

        // P0 held high with DEB_LEN=5: rises after 5 ticks, not before
        raw_p[0] = 1'b1;
        found = 1'b0; cnt = 0;
        for (int i = 1; i <= 2000 && !found; i++) begin
            step();
            if (dat_p[0]) begin found = 1'b1; cnt = i; end
        end
        chk("p0_rise_seen",      {31'h0, found}, 32'h1);
        chk("p0_rise_not_early", {31'h0, cnt >= 4 * PRESC + 3}, 32'h1);
        chk("p0_rise_not_late",  {31'h0, cnt <= 5 * PRESC + 2}, 32'h1);

        // 3-tick pulse on N2 is filtered
        wr_reg(32'h04, 32'hFFFF);
        wr_reg(32'h08, 32'hFFFF);
        raw_n[2] = 1'b1;
        steps(3 * PRESC);
        raw_n[2] = 1'b0;
        chk("n2_pulse_mid", {24'h0, dat_n}, 32'h0);
        steps(800);
        chk("n2_pulse_end", {24'h0, dat_n}, 32'h0);
        rd_chk("n2_status", 32'h0C, 32'h0);
        wr_reg(32'h04, 32'h0);
        wr_reg(32'h08, 32'h0);

        // Edge capture, W1C, irq
        raw_p[0] = 1'b0;
        raw_n[0] = 1'b1;
        steps(800);
        wr_reg(32'h0C, 32'hFFFF);
        wr_reg(32'h04, 32'h0001);
        wr_reg(32'h08, 32'h0100);
        raw_p[0] = 1'b1;
        steps(800);
        raw_n[0] = 1'b0;
        steps(800);
        rd_chk("status_both", 32'h0C, IRQ_ON ? 32'h0101 : 32'h0);
        chk("irq_set", {31'h0, irq}, {31'h0, IRQ_ON});
        wr_reg(32'h0C, 32'h0001);
        rd_chk("status_w1c_p0", 32'h0C, IRQ_ON ? 32'h0100 : 32'h0);
        chk("irq_still", {31'h0, irq}, {31'h0, IRQ_ON});
        wr_reg(32'h0C, 32'h0100);
        step();
        chk("irq_drop", {31'h0, irq}, 32'h0);
        rd_chk("status_empty", 32'h0C, 32'h0);
        wr_reg(32'h04, 32'h0);
        wr_reg(32'h08, 32'h0);

        // Bypass: 3-cycle latency
        wr_reg(32'h00, 32'h0);
        steps(4);
        old = raw_p[3];
        raw_p[3] = ~old;
        steps(2);
        chk("bypass_2cyc", {31'h0, dat_p[3]}, {31'h0, old});
        step();
        chk("bypass_3cyc", {31'h0, dat_p[3]}, {31'h0, ~old});

        // Random bypass traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                raw_p = 8'($urandom);
                raw_n = 8'($urandom);
            end
            step();
        end

        // Random debounce traffic with DEB_LEN=2
        wr_reg(32'h00, 32'd2);
        for (int k = 0; k < 30; k++) begin
            mask = 16'($urandom) & 16'($urandom);
            {raw_n, raw_p} = {raw_n, raw_p} ^ mask;
            steps($urandom_range(20, 400));
        end
        steps(700);
        rd_chk("stable_settled", 32'h10, {16'h0, raw_n, raw_p});
        rd_chk("sync_settled",   32'h14, {16'h0, raw_n, raw_p});

        // Reset in the middle of a count
        wr_reg(32'h00, 32'd5);
        raw_p = 8'hFF; raw_n = 8'h00;
        steps(700);
        raw_n[1] = 1'b1;
        steps(300);
        sys_addr = 32'h10; sys_ren = 1'b1;
        step();
        sys_ren = 1'b0;
        chk("pre_rst_ack", {31'h0, sys_ack}, 32'h1);
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_dat",   {16'h0, dat_n, dat_p}, 32'h0);
        chk("mid_rst_irq",   {31'h0, irq}, 32'h0);
        chk("mid_rst_ack",   {31'h0, sys_ack}, 32'h0);
        chk("mid_rst_rdata", sys_rdata, 32'h0);
        raw_p = '0; raw_n = '0;
        steps(2);
        rstn = 1'b1;
        step();
        rd_chk("deblen_after_rst", 32'h00, 32'd1000);
        steps(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/red_pitaya_exp_debounce.md
RED_PITAYA_EXP_DEBOUNCE -- requirements
Module: red_pitaya_exp_debounce

Interface
REQ-001 SHALL have parameter DWE, default 8: expansion connector width per polarity (P and N).
REQ-002 SHALL have parameter PRESC, default 125: clk_i cycles per debounce tick (1 us at 125 MHz).
REQ-003 SHALL have port clk_i, input, 1: the only clock.
REQ-004 SHALL have port rstn_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports exp_p_raw_i / exp_n_raw_i, input, DWE each: raw asynchronous connector pins.
REQ-006 SHALL have ports exp_p_dat_o / exp_n_dat_o, output, DWE each: debounced levels, which feed the housekeeping block's exp_*_dat_i.
REQ-007 SHALL have port irq_o, output, 1: level interrupt.
REQ-008 SHALL have sys bus slave ports: sys_addr (in, 32), sys_wdata (in, 32), sys_sel (in, 4), sys_wen (in, 1), sys_ren (in, 1), sys_rdata (out, 32), sys_err (out, 1), sys_ack (out, 1).

Function
REQ-009 SHALL pass each raw bit through a 2-flop synchronizer before any other logic.
REQ-010 SHALL generate a one-cycle tick every PRESC clk_i cycles from a free-running prescaler that wraps PRESC-1 -> 0.
REQ-011 SHALL keep one 16-bit counter per bit (2*DWE counters): sync == stable -> counter = 0; sync != stable -> counter increments on each tick; counter reaches DEB_LEN -> stable = sync and counter = 0.
REQ-012 SHALL, when DEB_LEN = 0, make stable follow sync every cycle (bypass); latency raw->dat_o is then 3 cycles.
REQ-013 SHALL, when a bit glitches back to stable before DEB_LEN ticks, clear that bit's counter; no output change results.
REQ-014 SHALL set sticky status bit i on a stable 0->1 transition when RISE_EN[i] = 1, and on a stable 1->0 transition when FALL_EN[i] = 1.
REQ-015 SHALL clear status bits by writing 1 to them (W1C); when a set and a clear hit the same bit in the same cycle, the set wins.
REQ-016 SHALL drive irq_o = OR of all status bits, registered: 1 cycle after a status bit sets.
REQ-017 SHALL use this register map (bit packing [DWE-1:0] = P, [2*DWE-1:DWE] = N): 0x00 DEB_LEN[15:0] RW; 0x04 RISE_EN RW; 0x08 FALL_EN RW; 0x0C STATUS W1C; 0x10 STABLE RO; 0x14 SYNC RO.
REQ-018 SHALL assert sys_ack exactly one cycle after sys_wen or sys_ren; sys_rdata SHALL be valid in the ack cycle; sys_err SHALL be 0 always.
REQ-019 SHALL ack unmapped addresses, returning rdata 0 with writes ignored; writes to RO registers SHALL be ignored.
REQ-020 SHALL apply a DEB_LEN change to in-progress counts immediately; a counter already >= the new DEB_LEN SHALL update stable on the next tick.

Reset
REQ-021 SHALL, on rstn_i low, asynchronously clear the synchronizers, counters, prescaler, stable, STATUS, RISE_EN, FALL_EN, irq_o, sys_ack and sys_rdata; DEB_LEN SHALL reset to 16'd1000.
REQ-022 SHALL, on reset release, ensure no edge is reported for the first sampled stable value (stable starts at 0, and RISE_EN = 0).

Configuration
REQ-023 SHALL, with EXP_DEB_IRQ_EN defined, implement REQ-014..016 fully.
REQ-024 SHALL, with EXP_DEB_IRQ_EN undefined, omit edge/status logic; irq_o SHALL be tied 0, and 0x04/0x08/0x0C SHALL read 0 and ignore writes.

Structure
REQ-025 SHALL place register offsets, the DEB_LEN reset value and the 16-bit counter width in a shared package, red_pitaya_exp_pkg.
REQ-026 SHALL put one bit's synchronizer + counter + stable flop in sub-module red_pitaya_deb_bit, instantiated 2*DWE times.

Verification
REQ-027 SHALL cover DEB_LEN = 5, raw P0 0->1 held: dat_o[0] rises after 5 ticks (about 625 cycles plus sync latency), not earlier.
REQ-028 SHALL cover DEB_LEN = 5, 3-tick pulse on N2: exp_n_dat_o stays 0 and STATUS = 0.
REQ-029 SHALL cover RISE_EN = 0x0001, FALL_EN = 0x0100, P0 rises then N0 falls (N0 held 1 first): STATUS reads 0x0101 and irq_o = 1; write 0x0001 to 0x0C leaves 0x0100; write 0x0100 drops irq_o.
REQ-030 SHALL cover DEB_LEN = 0: raw toggle appears on dat_o 3 cycles later.
REQ-031 SHALL cover a read of 0x20: ack after 1 cycle, rdata = 0, err = 0; a write of 0x1234 to 0x10 leaves STABLE unchanged.
REQ-032 SHALL cover rstn_i asserted mid-count: all outputs are 0 immediately, and DEB_LEN reads 1000 after release.
